// File: rtl/ahb_master_arb.sv
// ahb_master_arb: N-to-1 AHB-Lite master arbiter with a per-master hold
// register. Uncontended transfers pass straight through with zero added
// wait states. A live request that loses arbitration is parked in its hold
// register, and that master's hready is stalled until the request is issued.
//
// Ports
//   clk, reset          rising-edge clock, synchronous active-high reset
//   m_*                 packed master-side buses, master i in slice i
//   m_hrdata            slave read data broadcast to every master
//   m_hready/m_hresp    per-master ready / response
//   s_*                 forwarded address phase, write data and select
//   s_hreadyin          looped back from s_hreadyout
//   s_hrdata/s_hreadyout/s_hresp  slave returns
//   grant_id            master currently owning the address phase
module ahb_master_arb #(
  parameter int unsigned NUM_MASTERS = 3,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ARB_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_haddr,
  input  logic [NUM_MASTERS-1:0]        m_hwrite,
  input  logic [NUM_MASTERS*3-1:0]      m_hsize,
  input  logic [NUM_MASTERS*3-1:0]      m_hburst,
  input  logic [NUM_MASTERS*4-1:0]      m_hprot,
  input  logic [NUM_MASTERS*2-1:0]      m_htrans,
  input  logic [NUM_MASTERS-1:0]        m_hmastlock,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_hwdata,
  output logic [DATA_W-1:0]             m_hrdata,
  output logic [NUM_MASTERS-1:0]        m_hready,
  output logic [NUM_MASTERS-1:0]        m_hresp,
  output logic [ADDR_W-1:0]             s_haddr,
  output logic                          s_hwrite,
  output logic [2:0]                    s_hsize,
  output logic [2:0]                    s_hburst,
  output logic [3:0]                    s_hprot,
  output logic [1:0]                    s_htrans,
  output logic                          s_hmastlock,
  output logic [DATA_W-1:0]             s_hwdata,
  output logic                          s_hsel,
  output logic                          s_hreadyin,
  input  logic [DATA_W-1:0]             s_hrdata,
  input  logic                          s_hreadyout,
  input  logic                          s_hresp,
  output logic [2:0]                    grant_id
);

  localparam int unsigned IDX_W = 3;
  localparam logic [1:0] TR_IDLE = 2'b00;
  localparam logic [1:0] TR_BUSY = 2'b01;
  localparam logic [1:0] TR_SEQ  = 2'b11;

  // Address-phase payload; htrans kept apart so the idle-hold copy can omit it.
  typedef struct packed {
    logic [ADDR_W-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
    logic [2:0]        hburst;
    logic [3:0]        hprot;
    logic              hmastlock;
  } xfer_t;

  typedef struct packed {
    xfer_t      x;
    logic [1:0] htrans;
  } addr_phase_t;

  addr_phase_t            live_ap [NUM_MASTERS];
  addr_phase_t            eff_ap  [NUM_MASTERS];
  addr_phase_t            hold_q  [NUM_MASTERS];
  addr_phase_t            gnt_ap;
  xfer_t                  last_q;
  logic [NUM_MASTERS-1:0] pend_q;
  logic [NUM_MASTERS-1:0] is_down;
  logic [NUM_MASTERS-1:0] live;
  logic [NUM_MASTERS-1:0] cand;
  logic [NUM_MASTERS-1:0] gnt_oh;
  logic                   dvalid_q;
  logic                   lock_q;
  logic [IDX_W-1:0]       downer_q;
  logic [IDX_W-1:0]       owner_q;
  logic [IDX_W-1:0]       rr_q;
  logic [IDX_W-1:0]       sel;
  logic [1:0]             owner_tr;
  logic                   blocked;
  logic                   found;
  logic                   gnt_valid;

  // Per-master unpack, ready/response steering and candidate detection.
  for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_master
    assign live_ap[g] = {m_haddr[g*ADDR_W +: ADDR_W], m_hwrite[g], m_hsize[g*3 +: 3],
                         m_hburst[g*3 +: 3], m_hprot[g*4 +: 4], m_hmastlock[g],
                         m_htrans[g*2 +: 2]};
    assign is_down[g]  = dvalid_q && (downer_q == IDX_W'(g));
    assign m_hready[g] = pend_q[g] ? 1'b0 : (is_down[g] ? s_hreadyout : 1'b1);
    assign m_hresp[g]  = is_down[g] & s_hresp;
    assign live[g]     = live_ap[g].htrans[1] & m_hready[g];
    assign eff_ap[g]   = pend_q[g] ? hold_q[g] : live_ap[g];
    assign cand[g]     = pend_q[g] | live[g];
  end

  // Arbitration: the owner keeps the bus through SEQ/BUSY or an active lock.
  always_comb begin
    owner_tr  = TR_IDLE;
    sel       = owner_q;
    found     = 1'b0;
    gnt_ap    = '0;
    gnt_oh    = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (owner_q == IDX_W'(i)) owner_tr = eff_ap[i].htrans;
    end
    blocked = lock_q || (owner_tr == TR_SEQ) || (owner_tr == TR_BUSY);
    if (!blocked) begin
      if (ARB_MODE == 0) begin
        for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
          if (!found && cand[i]) begin
            sel   = IDX_W'(i);
            found = 1'b1;
          end
        end
      end else begin
        // Search upward from the index after the last grant, wrapping.
        for (int unsigned k = 1; k <= NUM_MASTERS; k++) begin
          for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
            if (!found && cand[i] && (((32'(rr_q) + k) % NUM_MASTERS) == i)) begin
              sel   = IDX_W'(i);
              found = 1'b1;
            end
          end
        end
      end
    end
    gnt_valid = s_hreadyout && (blocked || found);
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (sel == IDX_W'(i)) begin
        gnt_ap    = eff_ap[i];
        gnt_oh[i] = gnt_valid;
      end
    end
  end

  // Write data follows the data-phase owner.
  always_comb begin
    s_hwdata = '0;
    for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
      if (downer_q == IDX_W'(i)) s_hwdata = m_hwdata[i*DATA_W +: DATA_W];
    end
  end

  // Hold registers, ownership, lock and data-phase tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_q   <= '0;
      dvalid_q <= 1'b0;
      lock_q   <= 1'b0;
      downer_q <= '0;
      owner_q  <= '0;
      rr_q     <= IDX_W'(NUM_MASTERS - 1);
      last_q   <= '0;
      for (int unsigned i = 0; i < NUM_MASTERS; i++) hold_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_MASTERS; i++) begin
        if (gnt_oh[i]) begin
          pend_q[i] <= 1'b0;
        end else if (live[i]) begin
          pend_q[i] <= 1'b1;
          hold_q[i] <= live_ap[i];
        end
      end
      if (gnt_valid) begin
        owner_q <= sel;
        rr_q    <= sel;
        last_q  <= gnt_ap.x;
        lock_q  <= gnt_ap.x.hmastlock && (gnt_ap.htrans != TR_IDLE);
      end
      if (gnt_valid && gnt_ap.htrans[1]) begin
        dvalid_q <= 1'b1;
        downer_q <= sel;
      end else if (s_hreadyout) begin
        dvalid_q <= 1'b0;
      end
    end
  end

  // Forwarded address phase; idle outputs hold the last granted values.
  assign s_haddr     = gnt_valid ? gnt_ap.x.haddr     : last_q.haddr;
  assign s_hwrite    = gnt_valid ? gnt_ap.x.hwrite    : last_q.hwrite;
  assign s_hsize     = gnt_valid ? gnt_ap.x.hsize     : last_q.hsize;
  assign s_hburst    = gnt_valid ? gnt_ap.x.hburst    : last_q.hburst;
  assign s_hprot     = gnt_valid ? gnt_ap.x.hprot     : last_q.hprot;
  assign s_hmastlock = gnt_valid ? gnt_ap.x.hmastlock : last_q.hmastlock;
  assign s_htrans    = gnt_valid ? gnt_ap.htrans      : TR_IDLE;
  assign s_hsel      = gnt_valid;
  assign s_hreadyin  = s_hreadyout;
  assign m_hrdata    = s_hrdata;
  assign grant_id    = owner_q;

endmodule

// File: doc/ahb_master_arb.md
AHB_MASTER_ARB -- requirements
Module: ahb_master_arb

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 3, number of AHB-Lite master ports (2..8).
REQ-002 SHALL have parameter ADDR_W, default 32, address width.
REQ-003 SHALL have parameter DATA_W, default 32, data width.
REQ-004 SHALL have parameter ARB_MODE, default 1: 0 = fixed priority (lowest index wins), 1 = round-robin.
REQ-005 SHALL use one clock and a synchronous, active-high reset:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
REQ-006 SHALL have these master-side ports, with master i occupying slice i of each packed bus:
- m_haddr  in  NUM_MASTERS*ADDR_W  addresses
- m_hwrite  in  NUM_MASTERS  write flags
- m_hsize  in  NUM_MASTERS*3  sizes
- m_hburst  in  NUM_MASTERS*3  bursts
- m_hprot  in  NUM_MASTERS*4  protection
- m_htrans  in  NUM_MASTERS*2  transfer types
- m_hmastlock  in  NUM_MASTERS  lock requests
- m_hwdata  in  NUM_MASTERS*DATA_W  write data
- m_hrdata  out  DATA_W  read data, broadcast to all masters
- m_hready  out  NUM_MASTERS  per-master ready
- m_hresp  out  NUM_MASTERS  per-master response
REQ-007 SHALL have these slave-side ports:
- s_haddr/s_hwrite/s_hsize/s_hburst/s_hprot/s_htrans/s_hmastlock/s_hwdata  out  as master widths  forwarded transfer
- s_hsel  out  1  slave select
- s_hreadyin  out  1  equals s_hreadyout
- s_hrdata  in  DATA_W  slave read data
- s_hreadyout  in  1  slave ready
- s_hresp  in  1  slave response
- grant_id  out  3  master currently owning the address phase

Function
REQ-008 A request from master i SHALL be live when m_htrans[i][1]=1 and m_hready[i]=1.
REQ-009 Each master SHALL have one hold register (address-phase signals) plus a pend flag.
REQ-010 A live request that is not granted SHALL be captured into the hold register, setting pend on the next edge.
REQ-011 Arbitration SHALL happen only in cycles with s_hreadyout=1; candidates are masters with pend=1 or a live request.
REQ-012 For a candidate, a held request SHALL take precedence over that master's live signals.
REQ-013 Fixed priority mode SHALL grant the lowest-index candidate.
REQ-014 Round-robin mode SHALL grant the first candidate after the last granted index, searching upward with wrap-around from NUM_MASTERS-1 to 0.
REQ-015 Re-arbitration SHALL be blocked, and the grant kept by the owner, while the owner drives SEQ or BUSY.
REQ-016 Re-arbitration SHALL also be blocked while the owner's last issued transfer had hmastlock=1; the lock SHALL be released on the first owner transfer with hmastlock=0 or htrans=IDLE.
REQ-017 On a grant, the chosen transfer SHALL drive the s_* outputs combinationally.
REQ-018 On a grant, s_hsel SHALL be 1 and the granted master's pend SHALL clear at that edge.
REQ-019 With no grant, the block SHALL drive s_htrans=IDLE and s_hsel=0, with the other s_* outputs held at their last values.
REQ-020 The data-phase owner (downer, dvalid) SHALL be registered when a granted NONSEQ/SEQ is accepted with s_hreadyout=1.
REQ-021 s_hwdata SHALL be the downer's m_hwdata.
REQ-022 The dvalid flag SHALL clear after a completed data phase that has no new grant.
REQ-023 m_hready[i] SHALL be 0 if pend[i]=1.
REQ-024 Otherwise m_hready[i] SHALL be s_hreadyout if dvalid=1 and downer=i, else 1.
REQ-025 m_hresp[i] SHALL be s_hresp when dvalid=1 and downer=i, else 0.
REQ-026 m_hrdata SHALL be s_hrdata combinationally, with zero latency.
REQ-027 An uncontended transfer SHALL add zero wait states.
REQ-028 A held request SHALL add one or more wait states to its master.
REQ-029 On a two-cycle ERROR, the first cycle SHALL pass through to downer and arbitration SHALL be suppressed.
REQ-030 When a live request and the current downer's final hready fall in the same cycle, data-phase completion SHALL occur first, then the grant.
REQ-031 A master in pend SHALL never have its held transfer dropped, and its m_htrans changes SHALL be ignored until it is issued.

Reset
REQ-032 On reset=1 at a clk edge, the following SHALL be cleared: all pend, dvalid=0, lock=0, round-robin pointer=NUM_MASTERS-1 (so master 0 wins first), grant_id=0.
REQ-033 Output values SHALL be valid from the first edge after reset: s_htrans=IDLE, s_hsel=0, m_hready all 1, m_hresp all 0.
REQ-034 Reset mid-transfer SHALL discard held requests; slave transfers in flight are not completed.

Verification
REQ-035 Single master 1 NONSEQ read 0x100, slave zero-wait returns 0xCAFE -> s_haddr=0x100 same cycle, m_hready[1]=1 throughout, m_hrdata=0xCAFE.
REQ-036 Masters 0,1,2 issue NONSEQ simultaneously, ARB_MODE=1 -> grants 0,1,2 on consecutive cycles; m_hready[1] low 1 cycle, m_hready[2] low 2 cycles; held addresses reach slave unchanged.
REQ-037 ARB_MODE=0, master 0 requests every cycle, master 2 once -> master 2 stays pend until master 0 issues IDLE; no transfer is lost.
REQ-038 Master 1 4-beat INCR burst with master 0 contending -> 4 consecutive s_haddr from master 1, then master 0 granted.
REQ-039 Master 0 locked pair (hmastlock=1 then 0) while master 2 pends -> master 2 is granted only after the unlocked beat.
REQ-040 Slave ERROR to master 1 while master 0 pends -> m_hresp[1]=1 for 2 cycles, m_hready[1]=0 then 1, m_hresp[0]=0, master 0 granted after the error; reset asserted mid-burst -> all outputs at reset values next cycle.
